uart_tx_core: RTL and testbench

Serial transmit engine directly downstream of the UART register file. It takes the held byte, the baud divisor, the start/stop-bit controls and the "data pending" flag from the register file. It produces the TX line and a one-cycle `tx_done` pulse, which the register file uses to clear its pending flag and raise the TX interrupt status. The engine uses 8N1 or 8N2 framing, LSB first, with bit timing derived from an oversampled baud tick.

---
 rtl/uart_tx_core.sv | 141 ++++++++++++++
 tb/tb_uart_tx_core.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// UART transmit engine: 8N1/8N2 framing, LSB first; tx goes low on the accept edge, done pulses in the frame's last clock.
// Inputs are sampled only at frame accept (tx_start & full in IDLE) and ignored while busy; one idle clock separates frames.
module uart_tx_core #(
    parameter int OVERSAMPLE = 16,
    parameter int DVSR_W     = 11
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_data_in,
    input  logic [DVSR_W-1:0] i_dvsr,
    input  logic              i_tx_start,
    input  logic              i_full,
    input  logic              i_snum,
    output logic              o_tx,
    output logic              o_tx_busy,
    output logic              o_tx_done
);

    localparam int BC_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            r_state;
    logic [7:0]        r_shift;
    logic [DVSR_W-1:0] r_dvsr_q;
    logic [DVSR_W-1:0] r_cnt;
    logic [BC_W-1:0]   r_bcnt;
    logic [2:0]        r_idx;
    logic              r_snum_q;
    logic              r_stop_idx;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;

    logic              w_active;
    logic              w_tick;
    logic              w_bit_end;
    logic              w_accept;
    logic              w_last_stop;
    logic              w_done_nxt;
    logic [DVSR_W-1:0] w_cnt_nxt;
    logic [BC_W-1:0]   w_bcnt_nxt;

    always_comb begin
        w_active    = (r_state != IDLE);
        w_tick      = w_active && (r_cnt == r_dvsr_q);
        w_bit_end   = w_tick && (r_bcnt == BC_LAST);
        w_accept    = (r_state == IDLE) && i_tx_start && i_full;
        w_last_stop = (r_state == STOP) && (r_stop_idx == r_snum_q);

        w_cnt_nxt = r_cnt + 1'b1;
        if (!w_active || w_tick) begin
            w_cnt_nxt = '0;
        end

        w_bcnt_nxt = r_bcnt;
        if (!w_active) begin
            w_bcnt_nxt = '0;
        end else if (w_tick) begin
            w_bcnt_nxt = (r_bcnt == BC_LAST) ? '0 : r_bcnt + 1'b1;
        end

        // Registered done must lead the final tick by one clock: raise it when
        // the next cycle's counters will hold the last tick of the last stop bit.
        w_done_nxt = w_last_stop && !w_bit_end &&
                     (w_bcnt_nxt == BC_LAST) && (w_cnt_nxt == r_dvsr_q);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_dvsr_q   <= '0;
            r_cnt      <= '0;
            r_bcnt     <= '0;
            r_idx      <= '0;
            r_snum_q   <= 1'b0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_bcnt <= w_bcnt_nxt;
            r_done <= w_done_nxt;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift    <= i_data_in;
                        r_dvsr_q   <= i_dvsr;
                        r_snum_q   <= i_snum;
                        r_idx      <= '0;
                        r_stop_idx <= 1'b0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_tx    <= r_shift[0];
                        r_idx   <= '0;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_idx == 3'd7) begin
                            r_tx       <= 1'b1;
                            r_stop_idx <= 1'b0;
                            r_state    <= STOP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                            r_tx  <= r_shift[1];
                        end
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        if (r_stop_idx == r_snum_q) begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_tx      = r_tx;
    assign o_tx_busy = r_busy;
    assign o_tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: every clock of each frame checked against the frame timing formula.
module tb_uart_tx_core;

    logic        i_clk;
    logic        i_rst_n;
    logic [7:0]  i_data_in;
    logic [10:0] i_dvsr;
    logic        i_tx_start;
    logic        i_full;
    logic        i_snum;
    logic        o_tx;
    logic        o_tx_busy;
    logic        o_tx_done;

    int n_cmp;
    int n_bad;

    int       n_done;
    int       n_start;
    int       t_done1;
    int       t_start1;
    int       t_start2;
    int       writes;
    logic     prev_busy;
    logic [7:0] rx1;
    logic [7:0] rx2;

    uart_tx_core #(.OVERSAMPLE(16), .DVSR_W(11)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_data_in  (i_data_in),
        .i_dvsr     (i_dvsr),
        .i_tx_start (i_tx_start),
        .i_full     (i_full),
        .i_snum     (i_snum),
        .o_tx       (o_tx),
        .o_tx_busy  (o_tx_busy),
        .o_tx_done  (o_tx_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input int k, input logic got, input logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d got=%b exp=%b", tag, k, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; the following posedge is the accept edge (cycle 0).
    task automatic run_frame(input logic [7:0] b, input int d, input bit s,
                             input int chg_k, input int abort_k);
        int bl;
        int nb;
        logic etx;
        i_data_in  = b;
        i_dvsr     = 11'(d);
        i_snum     = s;
        i_tx_start = 1'b1;
        i_full     = 1'b1;
        bl = 16 * (d + 1);
        nb = s ? 11 : 10;
        @(posedge i_clk);
        for (int k = 1; k <= nb * bl + 1; k++) begin
            @(negedge i_clk);
            if (k <= bl)          etx = 1'b0;
            else if (k <= 9 * bl) etx = b[3'((k - 1) / bl - 1)];
            else                  etx = 1'b1;
            chk("tx",   k, o_tx,      etx);
            chk("busy", k, o_tx_busy, logic'(k <= nb * bl));
            chk("done", k, o_tx_done, logic'(k == nb * bl));
            if (k == 1) i_full = 1'b0;
            if (k == chg_k) begin
                i_dvsr    = 11'd7;
                i_data_in = 8'hFF;
                i_snum    = 1'b1;
                i_full    = 1'b1;
            end
            if (k == chg_k + 1) i_full = 1'b0;
            if (k == abort_k) begin
                i_rst_n = 1'b0;
                #1;
                chk("rst_tx",   k, o_tx,      1'b1);
                chk("rst_busy", k, o_tx_busy, 1'b0);
                chk("rst_done", k, o_tx_done, 1'b0);
                for (int j = 0; j < 3; j++) begin
                    @(negedge i_clk);
                    chk("rst_hold_done", k + j + 1, o_tx_done, 1'b0);
                    chk("rst_hold_tx",   k + j + 1, o_tx,      1'b1);
                end
                i_rst_n = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        i_rst_n    = 1'b0;
        i_data_in  = 8'h00;
        i_dvsr     = 11'd0;
        i_tx_start = 1'b0;
        i_full     = 1'b0;
        i_snum     = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("reset_tx",   0, o_tx,      1'b1);
        chk("reset_busy", 0, o_tx_busy, 1'b0);
        chk("reset_done", 0, o_tx_done, 1'b0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // 8N1, fastest divisor, 0xA5
        run_frame(8'hA5, 0, 1'b0, -1, -1);
        i_tx_start = 1'b0;
        repeat (2) @(negedge i_clk);

        // 8N2, dvsr=3, all-zero byte
        run_frame(8'h00, 3, 1'b1, -1, -1);
        repeat (2) @(negedge i_clk);

        // Mid-frame input changes must not disturb the frame
        run_frame(8'h3C, 1, 1'b0, 50, -1);
        repeat (2) @(negedge i_clk);

        // Enable without pending data
        i_tx_start = 1'b1;
        i_full     = 1'b0;
        i_dvsr     = 11'd0;
        i_snum     = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge i_clk);
            if (k % 50 == 0) begin
                chk("idle_tx",   k, o_tx,      1'b1);
                chk("idle_busy", k, o_tx_busy, 1'b0);
                chk("idle_done", k, o_tx_done, 1'b0);
            end
        end
        run_frame(8'h96, 0, 1'b0, -1, -1);
        repeat (2) @(negedge i_clk);

        // Reset during a frame, then a clean frame
        run_frame(8'hE7, 0, 1'b0, -1, 70);
        @(negedge i_clk);
        chk("post_rst_busy", 0, o_tx_busy, 1'b0);
        run_frame(8'h81, 0, 1'b0, -1, -1);
        repeat (2) @(negedge i_clk);

        // Back-to-back with a register-file model: full cleared on done, rewritten 2 clocks later
        n_done    = 0;
        n_start   = 0;
        t_done1   = -1;
        t_start1  = -1;
        t_start2  = -1;
        rx1       = 8'h00;
        rx2       = 8'h00;
        prev_busy = 1'b0;
        i_dvsr     = 11'd0;
        i_snum     = 1'b0;
        i_tx_start = 1'b1;
        i_data_in  = 8'h5A;
        i_full     = 1'b1;
        writes     = 1;
        for (int n = 0; n < 400; n++) begin
            @(negedge i_clk);
            if (o_tx_busy && !prev_busy) begin
                n_start++;
                if (n_start == 1) t_start1 = n;
                if (n_start == 2) t_start2 = n;
            end
            prev_busy = o_tx_busy;
            for (int i = 0; i < 8; i++) begin
                if (t_start1 >= 0 && n == t_start1 + (i + 1) * 16 + 7) rx1[i] = o_tx;
                if (t_start2 >= 0 && n == t_start2 + (i + 1) * 16 + 7) rx2[i] = o_tx;
            end
            if (o_tx_done) begin
                n_done++;
                if (n_done == 1) t_done1 = n;
                i_full = 1'b0;
            end
            if (writes == 1 && t_done1 >= 0 && n == t_done1 + 2) begin
                i_data_in = 8'hC3;
                i_full    = 1'b1;
                writes    = 2;
            end
        end
        chk_int("b2b_starts", n_start, 2);
        chk_int("b2b_dones",  n_done,  2);
        chk_int("b2b_gap",    t_start2 - t_done1, 3);
        chk_int("b2b_rx1",    int'(rx1), 32'h5A);
        chk_int("b2b_rx2",    int'(rx2), 32'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
